// File: rtl/core_pkg.sv
// Shared ID/EX definitions: control-bit positions, the all-zero bubble control word,
// and the state encoding of the multiply-occupancy FSM.
package core_pkg;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;
    localparam int M_MEMREAD   = 0;
    localparam int M_MEMWRITE  = 1;
    localparam int EX_ALUSRC   = 0;
    localparam int EX_REGDST   = 3;

    typedef struct packed {
        logic [1:0] wb;
        logic [1:0] m;
        logic [3:0] ex;
    } ctrl_t;

    // Zero WB/M control makes a slot invisible to forwarding, memory and writeback.
    localparam ctrl_t BUBBLE_CTRL = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded instruction from ID in, registered slot to forwarding/EX out.
// master = decode side driving ID fields; slave = the id_ex_stage register.
interface id_ex_stage_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_rs_i;
    logic [4:0]       IF_ID_rt_i;
    logic [4:0]       IF_ID_rd_i;
    logic [31:0]      RS_data_i;
    logic [31:0]      RT_data_i;
    logic [31:0]      imm_i;
    logic [1:0]       WB_i;
    logic [1:0]       M_i;
    logic [3:0]       EX_i;
    logic             mul_i;
    logic             flush_i;
    logic [4:0]       ID_EX_rs_o;
    logic [4:0]       ID_EX_rt_o;
    logic [4:0]       ID_EX_rd_o;
    logic [31:0]      ID_EX_RS_data_o;
    logic [31:0]      ID_EX_RT_data_o;
    logic [31:0]      ID_EX_imm_o;
    logic [1:0]       ID_EX_WB_o;
    logic [1:0]       ID_EX_M_o;
    logic [3:0]       ID_EX_EX_o;
    logic             ID_EX_valid_o;
    logic             stall_o;
    logic             ex_hold_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output IF_ID_rs_i, IF_ID_rt_i, IF_ID_rd_i, RS_data_i, RT_data_i, imm_i,
               WB_i, M_i, EX_i, mul_i, flush_i,
        input  ID_EX_rs_o, ID_EX_rt_o, ID_EX_rd_o, ID_EX_RS_data_o, ID_EX_RT_data_o,
               ID_EX_imm_o, ID_EX_WB_o, ID_EX_M_o, ID_EX_EX_o, ID_EX_valid_o,
               stall_o, ex_hold_o, bubble_cnt_o
    );

    modport slave (
        input  IF_ID_rs_i, IF_ID_rt_i, IF_ID_rd_i, RS_data_i, RT_data_i, imm_i,
               WB_i, M_i, EX_i, mul_i, flush_i,
        output ID_EX_rs_o, ID_EX_rt_o, ID_EX_rd_o, ID_EX_RS_data_o, ID_EX_RT_data_o,
               ID_EX_imm_o, ID_EX_WB_o, ID_EX_M_o, ID_EX_EX_o, ID_EX_valid_o,
               stall_o, ex_hold_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection against the load currently held in ID/EX.
// Latency: combinational. Backpressure: stall requested whole multiply occupancy, or on load-use unless flushed.
module hazard_detect
    import core_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       flush,
    input  logic       busy,
    output logic       lu,
    output logic       stall
);

    // $0 never carries a real dependency, so a load into it is ignored.
    assign lu    = ex_valid & ex_memread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign stall = busy | (lu & ~flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and saturating bubble counter.
// Latency: 1 cycle ID->EX. Backpressure: stall_o holds PC/IF-ID; with ID_EX_MUL_STALL_EN a multiply
// holds this stage (and EX/MEM via ex_hold_o) for MUL_LAT cycles total.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);

`ifdef ID_EX_MUL_STALL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [3:0]       mul_cnt;
    logic             pend_flush;
    logic [4:0]       rs_q, rt_q, rd_q;
    logic [31:0]      rs_data_q, rt_data_q, imm_q;
    ctrl_t            ctrl_q;
    logic             valid_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic  busy, lu, stall, bubble;
    ctrl_t ctrl_in;

    assign busy    = (state == MUL_BUSY);
    assign ctrl_in = '{wb: bus.WB_i, m: bus.M_i, ex: bus.EX_i};
    // A flush that arrived while the multiply held the stage is honoured at the first advance.
    assign bubble  = lu | bus.flush_i | pend_flush;

    hazard_detect u_hazard_detect (
        .ex_valid   (valid_q),
        .ex_memread (ctrl_q.m[M_MEMREAD]),
        .ex_rt      (rt_q),
        .id_rs      (bus.IF_ID_rs_i),
        .id_rt      (bus.IF_ID_rt_i),
        .flush      (bus.flush_i),
        .busy       (busy),
        .lu         (lu),
        .stall      (stall)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= RUN;
            mul_cnt      <= '0;
            pend_flush   <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            ctrl_q       <= BUBBLE_CTRL;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    rs_q      <= bus.IF_ID_rs_i;
                    rt_q      <= bus.IF_ID_rt_i;
                    rd_q      <= bus.IF_ID_rd_i;
                    rs_data_q <= bus.RS_data_i;
                    rt_data_q <= bus.RT_data_i;
                    imm_q     <= bus.imm_i;
                    if (bubble) begin
                        ctrl_q     <= BUBBLE_CTRL;
                        valid_q    <= 1'b0;
                        pend_flush <= 1'b0;
                        if (bubble_cnt_q != CNT_MAX)
                            bubble_cnt_q <= bubble_cnt_q + 1'b1;
                    end else begin
                        ctrl_q  <= ctrl_in;
                        valid_q <= 1'b1;
                        if (MUL_EN && bus.mul_i) begin
                            state   <= MUL_BUSY;
                            mul_cnt <= 4'(MUL_LAT - 1);
                        end
                    end
                end
                MUL_BUSY: begin
                    if (bus.flush_i)
                        pend_flush <= 1'b1;
                    mul_cnt <= mul_cnt - 4'd1;
                    if (mul_cnt == 4'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.ID_EX_rs_o      = rs_q;
    assign bus.ID_EX_rt_o      = rt_q;
    assign bus.ID_EX_rd_o      = rd_q;
    assign bus.ID_EX_RS_data_o = rs_data_q;
    assign bus.ID_EX_RT_data_o = rt_data_q;
    assign bus.ID_EX_imm_o     = imm_q;
    assign bus.ID_EX_WB_o      = ctrl_q.wb;
    assign bus.ID_EX_M_o       = ctrl_q.m;
    assign bus.ID_EX_EX_o      = ctrl_q.ex;
    assign bus.ID_EX_valid_o   = valid_q;
    assign bus.stall_o         = stall;
    assign bus.ex_hold_o       = MUL_EN & busy;
    assign bus.bubble_cnt_o    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instruction sequences, a cycle-level reference model
// compared every cycle, and literal expectations at the key points of each sequence.
module tb_id_ex_stage;

    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ID_EX_MUL_STALL_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    id_ex_stage_if #(.CNT_W(CNT_W)) bus ();

    id_ex_stage #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what the ID/EX slot must contain after each edge.
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [1:0]  m_wb, m_m;
    logic [3:0]  m_ex;
    bit          m_valid;
    int          m_cnt;
    int          busy_left;
    bit          pend;

    function automatic bit m_lu();
        return m_valid && m_m[0] && (m_rt != 5'd0) &&
               (m_rt == bus.IF_ID_rs_i || m_rt == bus.IF_ID_rt_i);
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm, m_wb, m_m, m_ex} = '0;
            m_valid = 0; m_cnt = 0; busy_left = 0; pend = 0;
        end else if (busy_left > 0) begin
            if (bus.flush_i) pend = 1;
            busy_left--;
        end else begin
            bit b;
            b = m_lu() || bus.flush_i || pend;
            m_rs = bus.IF_ID_rs_i; m_rt = bus.IF_ID_rt_i; m_rd = bus.IF_ID_rd_i;
            m_rsd = bus.RS_data_i; m_rtd = bus.RT_data_i; m_imm = bus.imm_i;
            if (b) begin
                m_wb = 0; m_m = 0; m_ex = 0; m_valid = 0; pend = 0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_wb = bus.WB_i; m_m = bus.M_i; m_ex = bus.EX_i; m_valid = 1;
                if (FEAT && bus.mul_i) busy_left = MUL_LAT - 1;
            end
        end
    end

    always @(negedge clk_i) begin
        logic [137:0] act, exp;
        bit e_stall, e_hold;
        e_hold  = busy_left > 0;
        e_stall = e_hold || (m_lu() && !bus.flush_i);
        act = {bus.ID_EX_rs_o, bus.ID_EX_rt_o, bus.ID_EX_rd_o, bus.ID_EX_RS_data_o,
               bus.ID_EX_RT_data_o, bus.ID_EX_imm_o, bus.ID_EX_WB_o, bus.ID_EX_M_o,
               bus.ID_EX_EX_o, bus.ID_EX_valid_o, bus.stall_o, bus.ex_hold_o, bus.bubble_cnt_o};
        exp = {m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm, m_wb, m_m, m_ex, m_valid,
               e_stall, e_hold, 16'(m_cnt)};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got %h, expected %h", $time, act, exp);
        end
    end

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [1:0] wb, input logic [1:0] m, input logic [3:0] ex,
                       input logic mul, input logic flush);
        bus.IF_ID_rs_i = rs;
        bus.IF_ID_rt_i = rt;
        bus.IF_ID_rd_i = rd;
        bus.RS_data_i  = 32'hA000_0000 | 32'(rs);
        bus.RT_data_i  = 32'hB000_0000 | 32'(rt);
        bus.imm_i      = 32'h0000_0100 + 32'(rd);
        bus.WB_i       = wb;
        bus.M_i        = m;
        bus.EX_i       = ex;
        bus.mul_i      = mul;
        bus.flush_i    = flush;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 2'b00, 2'b00, 4'b0000, 0, 0);
        #12;
        check("reset_valid", 32'(bus.ID_EX_valid_o), 0);
        check("reset_wb", 32'(bus.ID_EX_WB_o), 0);
        check("reset_cnt", 32'(bus.bubble_cnt_o), 0);
        check("reset_stall", 32'(bus.stall_o), 0);
        rst_i = 1'b1;
        step();

        // lw $2,0($1) ; add $3,$2,$4
        drv(1, 2, 0, 2'b11, 2'b01, 4'b0001, 0, 0);
        step();
        drv(2, 4, 3, 2'b01, 2'b00, 4'b1100, 0, 0);
        #1 check("lu_stall", 32'(bus.stall_o), 1);
        step();
        check("lu_bubble_valid", 32'(bus.ID_EX_valid_o), 0);
        check("lu_bubble_wb", 32'(bus.ID_EX_WB_o), 0);
        check("lu_cnt", 32'(bus.bubble_cnt_o), 1);
        check("lu_stall_release", 32'(bus.stall_o), 0);
        step();
        check("add_rd", 32'(bus.ID_EX_rd_o), 3);
        check("add_ex", 32'(bus.ID_EX_EX_o), 32'hC);

        // lw $0 ; add $3,$0,$4 : no dependency through $0
        drv(1, 0, 0, 2'b11, 2'b01, 4'b0001, 0, 0);
        step();
        drv(0, 4, 3, 2'b01, 2'b00, 4'b1100, 0, 0);
        #1 check("r0_no_stall", 32'(bus.stall_o), 0);
        step();
        check("r0_valid", 32'(bus.ID_EX_valid_o), 1);
        check("r0_cnt", 32'(bus.bubble_cnt_o), 1);

        // flush coinciding with load-use: one bubble, no stall
        drv(1, 5, 0, 2'b11, 2'b01, 4'b0001, 0, 0);
        step();
        drv(5, 6, 7, 2'b01, 2'b00, 4'b1100, 0, 1);
        #1 check("flush_lu_stall", 32'(bus.stall_o), 0);
        step();
        check("flush_valid", 32'(bus.ID_EX_valid_o), 0);
        check("flush_cnt", 32'(bus.bubble_cnt_o), 2);
        drv(0, 0, 0, 2'b00, 2'b00, 4'b0000, 0, 0);
        step();

        // multiply followed by add
        drv(6, 7, 8, 2'b01, 2'b00, 4'b1100, 1, 0);
        step();
        drv(8, 9, 10, 2'b01, 2'b00, 4'b1100, 0, 0);
        #1;
`ifdef ID_EX_MUL_STALL_EN
        check("mul_stall", 32'(bus.stall_o), 1);
        check("mul_hold", 32'(bus.ex_hold_o), 1);
        step();
        check("mul_hold_e1", 32'(bus.ex_hold_o), 1);
        check("mul_rd_e1", 32'(bus.ID_EX_rd_o), 8);
        step();
        check("mul_hold_e2", 32'(bus.ex_hold_o), 0);
        check("mul_rd_e2", 32'(bus.ID_EX_rd_o), 8);
        step();
        check("mul_add_rd", 32'(bus.ID_EX_rd_o), 10);

        // flush while the multiply occupies the stage
        drv(1, 2, 11, 2'b01, 2'b00, 4'b1100, 1, 0);
        step();
        drv(0, 0, 0, 2'b00, 2'b00, 4'b0000, 0, 1);
        step();
        drv(12, 13, 14, 2'b01, 2'b00, 4'b1100, 0, 0);
        step();
        check("pf_hold_rd", 32'(bus.ID_EX_rd_o), 11);
        step();
        check("pf_bubble_valid", 32'(bus.ID_EX_valid_o), 0);
        check("pf_cnt", 32'(bus.bubble_cnt_o), 3);
        step();
        check("pf_next_rd", 32'(bus.ID_EX_rd_o), 14);
        check("pf_next_valid", 32'(bus.ID_EX_valid_o), 1);
`else
        check("mul_ignored_hold", 32'(bus.ex_hold_o), 0);
        check("mul_ignored_stall", 32'(bus.stall_o), 0);
        step();
        check("mul_ignored_rd", 32'(bus.ID_EX_rd_o), 10);
`endif

        // saturation of the bubble counter
        drv(0, 0, 0, 2'b00, 2'b00, 4'b0000, 0, 1);
        repeat (CNT_MAX + 6) step();
        check("sat_cnt", 32'(bus.bubble_cnt_o), 32'hFFFF);
        step();
        check("sat_no_wrap", 32'(bus.bubble_cnt_o), 32'hFFFF);

        // reset asserted one cycle into a multiply
        drv(1, 2, 15, 2'b01, 2'b00, 4'b1100, 1, 0);
        step();
        drv(0, 0, 0, 2'b00, 2'b00, 4'b0000, 0, 0);
        #2 rst_i = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.ID_EX_valid_o), 0);
        check("rst_mid_rd", 32'(bus.ID_EX_rd_o), 0);
        check("rst_mid_hold", 32'(bus.ex_hold_o), 0);
        check("rst_mid_stall", 32'(bus.stall_o), 0);
        check("rst_mid_cnt", 32'(bus.bubble_cnt_o), 0);
        #8 rst_i = 1'b1;
        step();
        check("post_rst_valid", 32'(bus.ID_EX_valid_o), 1);
        check("post_rst_hold", 32'(bus.ex_hold_o), 0);
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
